pc_gen: RTL and testbench

//  Parametrised fetch-stage program-counter generator; successor to the fixed 32-bit PC register.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_gen.sv | 114 +++++++++++
 tb/tb_pc_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared states and defaults for the fetch-stage PC generator
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int          XLEN_DEFAULT      = 32;
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h0000_0100;

    // Low address bits that must be zero for a legal instruction address
    localparam logic [1:0]  ALIGN_MASK        = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack, oldest entry overwritten when full
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   top_inc;
    logic            do_pop;

    assign top_inc = top_q + PW'(1);
    assign do_pop  = pop_i && (count_q != '0);
    assign top_o   = mem_q[top_q];
    assign valid_o = (count_q != '0);

    always_comb begin
        mem_d   = mem_q;
        top_d   = top_q;
        count_d = count_q;
        if (push_i && do_pop) begin
            // Return consumed and a new call made: replace the top in place
            mem_d[top_q] = data_i;
        end else if (push_i) begin
            mem_d[top_inc] = data_i;
            top_d          = top_inc;
            if (count_q != CW'(RAS_DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (do_pop) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            top_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with halt, redirect/trap priority; PC_RAS_EN adds return prediction
module pc_gen
    import pc_pkg::*;
#(
    parameter int            XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT),
    parameter int            RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready_i,
    input  logic            halt_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o,
    output logic            ras_valid_o,
    output logic [1:0]      state_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            accept;
    logic            ras_push, ras_pop;
    logic            ras_valid;
    logic [XLEN-1:0] ras_top;

    assign pc_o        = pc_q;
    assign pc_valid_o  = (state_q == RUN);
    assign pc_plus4_o  = pc_q + XLEN'(4);
    assign misalign_o  = misalign_q;
    assign state_o     = state_q;
    assign ras_valid_o = ras_valid;
    assign accept      = pc_valid_o && fetch_ready_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (state_q == BOOT) begin
            // RESET_VEC is already in pc_q and becomes the first fetch
            state_d = RUN;
        end else if (trap_i) begin
            pc_d    = TRAP_VEC;
            state_d = RUN;
        end else if (redirect_i) begin
            state_d = RUN;
            if ((redirect_target_i[1:0] & ALIGN_MASK) != 2'b00) begin
                pc_d       = TRAP_VEC;
                misalign_d = 1'b1;
            end else begin
                pc_d = redirect_target_i;
            end
        end else if (state_q == RUN) begin
            if (accept) begin
                ras_push = call_i;
                if (ret_i && ras_valid) begin
                    ras_pop = 1'b1;
                    pc_d    = ras_top;
                end else begin
                    pc_d = pc_plus4_o;
                end
            end
            if (halt_i) begin
                state_d = HALT;
            end
        end else if (!halt_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_plus4_o),
        .top_o   (ras_top),
        .valid_o (ras_valid)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras;
    assign ras_valid  = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = ^{ras_push, ras_pop, ret_i};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen, RAS checks under PC_RAS_EN
module tb_pc_gen;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic        clk;
    logic        reset;
    logic        fetch_ready_i;
    logic        halt_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        trap_i;
    logic        call_i;
    logic        ret_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic [31:0] pc_plus4_o;
    logic        misalign_o;
    logic        ras_valid_o;
    logic [1:0]  state_o;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [1:0]  st;
        logic        rv;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_gen dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_ready_i     (fetch_ready_i),
        .halt_i            (halt_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .trap_i            (trap_i),
        .call_i            (call_i),
        .ret_i             (ret_i),
        .pc_o              (pc_o),
        .pc_valid_o        (pc_valid_o),
        .pc_plus4_o        (pc_plus4_o),
        .misalign_o        (misalign_o),
        .ras_valid_o       (ras_valid_o),
        .state_o           (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid fetch presented by the DUT is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (pc_valid_o) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fetch_unexpected: got pc=%h valid=1, expected no valid fetch", pc_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (pc_o !== e.pc || misalign_o !== e.mis || state_o !== e.st ||
                        ras_valid_o !== e.rv || pc_plus4_o !== e.pc + 32'd4) begin
                        n_fail++;
                        $display("FAIL fetch: got pc=%h p4=%h mis=%b st=%0d rv=%b, expected pc=%h p4=%h mis=%b st=%0d rv=%b",
                                 pc_o, pc_plus4_o, misalign_o, state_o, ras_valid_o,
                                 e.pc, e.pc + 32'd4, e.mis, e.st, e.rv);
                    end
                end
            end
        end
    end

    // One cycle: queue the expected fetch, or check an idle (valid=0) cycle directly
    task automatic tick(input logic v, input logic [31:0] pc, input logic mis,
                        input logic [1:0] st, input logic rv);
        if (v) begin
            exp_t e;
            e.pc = pc; e.mis = mis; e.st = st; e.rv = rv;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!v) begin
            n_tests++;
            if (pc_valid_o !== 1'b0 || pc_o !== pc || misalign_o !== mis ||
                state_o !== st || ras_valid_o !== rv) begin
                n_fail++;
                $display("FAIL idle: got valid=%b pc=%h mis=%b st=%0d rv=%b, expected valid=0 pc=%h mis=%b st=%0d rv=%b",
                         pc_valid_o, pc_o, misalign_o, state_o, ras_valid_o, pc, mis, st, rv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] pc, input logic rv);
        tick(1'b1, pc, 1'b0, ST_RUN, rv);
    endtask

    task automatic redir(input logic [31:0] tgt);
        redirect_i        = 1'b1;
        redirect_target_i = tgt;
    endtask

    task automatic clr;
        redirect_i = 1'b0;
        trap_i     = 1'b0;
        halt_i     = 1'b0;
        call_i     = 1'b0;
        ret_i      = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        fetch_ready_i     = 1'b1;
        redirect_target_i = '0;
        clr();

        // T1 reset and boot
        repeat (3) @(posedge clk);
        #1;
        tick(1'b0, 32'h1000, 1'b0, ST_BOOT, 1'b0);
        reset = 1'b0;
        tick(1'b0, 32'h1000, 1'b0, ST_BOOT, 1'b0);
        run(32'h1000, 1'b0);
        run(32'h1004, 1'b0);

        // T2 stall
        fetch_ready_i = 1'b0;
        repeat (4) run(32'h1008, 1'b0);
        fetch_ready_i = 1'b1;
        run(32'h1008, 1'b0);

        // T3 priority: trap beats redirect and halt; misaligned redirect traps
        trap_i = 1'b1; halt_i = 1'b1; redir(32'h2000);
        run(32'h100C, 1'b0);
        clr(); redir(32'h2002);
        run(32'h0100, 1'b0);
        clr();
        tick(1'b1, 32'h0100, 1'b1, ST_RUN, 1'b0);
        redir(32'h3000);
        run(32'h0104, 1'b0);
        clr();

        // T4 halt, then redirect out of HALT
        halt_i = 1'b1; fetch_ready_i = 1'b0;
        run(32'h3000, 1'b0);
        fetch_ready_i = 1'b1;
        tick(1'b0, 32'h3000, 1'b0, ST_HALT, 1'b0);
        redir(32'h4000);
        tick(1'b0, 32'h3000, 1'b0, ST_HALT, 1'b0);
        clr();
        run(32'h4000, 1'b0);

        // T5 wrap of the sequential sum
        redir(32'hFFFF_FFFC);
        run(32'h4004, 1'b0);
        clr();
        run(32'hFFFF_FFFC, 1'b0);
        redir(32'h0000_0010);
        run(32'h0000_0000, 1'b0);
        clr();

`ifdef PC_RAS_EN
        // T6 five calls into a 4-deep stack, then five returns
        for (int i = 1; i <= 5; i++) begin
            call_i = 1'b1;
            run(32'(i * 16), (i > 1));
            call_i = 1'b0;
            if (i < 5) redir(32'((i + 1) * 16));
            run(32'(i * 16 + 4), 1'b1);
            clr();
        end
        ret_i = 1'b1;
        run(32'h58, 1'b1);
        run(32'h54, 1'b1);
        run(32'h44, 1'b1);
        run(32'h34, 1'b1);
        run(32'h24, 1'b0);
        clr();
        run(32'h28, 1'b0);
`else
        // Without the stack, call/ret are plain sequential fetches
        call_i = 1'b1;
        run(32'h10, 1'b0);
        call_i = 1'b0; ret_i = 1'b1;
        run(32'h14, 1'b0);
        clr();
        run(32'h18, 1'b0);
`endif

        // Asynchronous reset mid-operation
        reset = 1'b1;
        tick(1'b0, 32'h1000, 1'b0, ST_BOOT, 1'b0);
        reset = 1'b0;

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected fetches never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
